// File: rtl/clock_pkg.sv
// clock_pkg: mode encodings, sel polarity and mode sequencing shared by the time-set logic.
package clock_pkg;
  typedef enum logic [1:0] {
    MODE_RUN     = 2'b00,
    MODE_SET_MIN = 2'b01,
    MODE_SET_HR  = 2'b10
  } mode_t;
  localparam logic SEL_TICK   = 1'b1;
  localparam logic SEL_MANUAL = 1'b0;
  function automatic mode_t next_mode(input mode_t m);
    return m == MODE_RUN ? MODE_SET_MIN : m == MODE_SET_MIN ? MODE_SET_HR : MODE_RUN;
  endfunction
endpackage

// File: rtl/btn_sync_edge.sv
// btn_sync_edge: 2-flop synchronizer plus registered rising-edge press flag for one button.
// o_level exists only when TIME_SET_AUTO_REPEAT_EN is defined.
module btn_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn,
`ifdef TIME_SET_AUTO_REPEAT_EN
  output logic o_level,
`endif
  output logic o_press
);
  logic r_s1, r_s2, r_hist, r_press;
  logic [1:0] r_live;
  // history holds at 1 until the synchronizer carries real samples, so a button held through reset never looks like a fresh press
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_hist  <= 1'b1;
      r_live  <= '0;
      r_press <= 1'b0;
    end else begin
      r_s1    <= i_btn;
      r_s2    <= r_s1;
      r_live  <= {r_live[0], 1'b1};
      r_hist  <= r_live[1] ? r_s2 : r_hist;
      r_press <= r_s2 & ~r_hist;
    end
  assign o_press = r_press;
`ifdef TIME_SET_AUTO_REPEAT_EN
  assign o_level = r_s2;
`endif
endmodule

// File: rtl/time_set_controller.sv
// time_set_controller: RUN/SET_MIN/SET_HR mode FSM issuing registered increment and seconds-clear pulses.
// Define TIME_SET_AUTO_REPEAT_EN to enable hold-to-repeat on btn_inc.
module time_set_controller
  import clock_pkg::*;
#(
  parameter int REPEAT_DELAY  = 50_000_000,
  parameter int REPEAT_PERIOD = 10_000_000,
  parameter int TIMEOUT_S     = 30
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_1hz,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic [1:0] mode,
  output logic       sel,
  output logic       inc_min,
  output logic       inc_hr,
  output logic       sec_clr
);
  localparam int IW = TIMEOUT_S > 0 ? $clog2(TIMEOUT_S + 1) : 1;
  localparam logic [IW-1:0] IDLE_MAX = IW'(TIMEOUT_S);
  mode_t r_mode, w_next;
  logic r_sel, r_inc_min, r_inc_hr, r_sec_clr;
  logic [IW-1:0] r_idle;
  logic w_mode_ev, w_inc_ev, w_rep_fire, w_set, w_legal, w_timeout, w_adv, w_bump;
`ifdef TIME_SET_AUTO_REPEAT_EN
  localparam int RMAX = REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW = RMAX > 1 ? $clog2(RMAX) : 1;
  localparam logic [RW-1:0] R_SAT = RW'(RMAX - 1);
  logic [RW-1:0] r_rep;
  logic r_rep_on, r_rep_first, w_inc_level, w_mode_level;
  btn_sync_edge u_mode (.clk(clk), .rst_n(rst_n), .i_btn(btn_mode), .o_level(w_mode_level), .o_press(w_mode_ev));
  btn_sync_edge u_inc (.clk(clk), .rst_n(rst_n), .i_btn(btn_inc), .o_level(w_inc_level), .o_press(w_inc_ev));
  // a held mode button means a state change is imminent, so repeats stop early
  assign w_rep_fire = r_rep_on && w_inc_level && !w_mode_level &&
                      r_rep == (r_rep_first ? RW'(REPEAT_DELAY - 1) : RW'(REPEAT_PERIOD - 1));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_rep       <= '0;
      r_rep_on    <= 1'b0;
      r_rep_first <= 1'b0;
    end else if (w_set && !w_adv && w_inc_ev) begin
      r_rep       <= '0;
      r_rep_on    <= 1'b1;
      r_rep_first <= 1'b1;
    end else if (!r_rep_on || !w_inc_level || w_mode_level || w_adv || !w_set) begin
      r_rep       <= '0;
      r_rep_on    <= 1'b0;
      r_rep_first <= 1'b0;
    end else if (w_rep_fire) begin
      r_rep       <= '0;
      r_rep_first <= 1'b0;
    end else if (r_rep != R_SAT) begin
      r_rep <= r_rep + RW'(1);
    end
`else
  btn_sync_edge u_mode (.clk(clk), .rst_n(rst_n), .i_btn(btn_mode), .o_press(w_mode_ev));
  btn_sync_edge u_inc (.clk(clk), .rst_n(rst_n), .i_btn(btn_inc), .o_press(w_inc_ev));
  assign w_rep_fire = 1'b0;
`endif
  assign w_set     = r_mode == MODE_SET_MIN || r_mode == MODE_SET_HR;
  assign w_legal   = w_set || r_mode == MODE_RUN;
  assign w_timeout = TIMEOUT_S != 0 && w_set && r_idle == IDLE_MAX;
  assign w_adv     = w_mode_ev || w_timeout;
  // mode events win over increments arriving in the same cycle
  assign w_bump    = w_set && !w_adv && (w_inc_ev || w_rep_fire);
  assign w_next    = !w_legal ? MODE_RUN : w_timeout ? MODE_RUN : w_mode_ev ? next_mode(r_mode) : r_mode;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_mode    <= MODE_RUN;
      r_sel     <= SEL_TICK;
      r_inc_min <= 1'b0;
      r_inc_hr  <= 1'b0;
      r_sec_clr <= 1'b0;
      r_idle    <= '0;
    end else begin
      r_mode    <= w_next;
      r_sel     <= w_next == MODE_RUN ? SEL_TICK : SEL_MANUAL;
      r_sec_clr <= r_mode == MODE_RUN && w_mode_ev;
      r_inc_min <= w_bump && r_mode == MODE_SET_MIN;
      r_inc_hr  <= w_bump && r_mode == MODE_SET_HR;
      r_idle    <= (!w_set || w_next != r_mode || w_mode_ev || w_inc_ev || w_bump) ? '0 :
                   (tick_1hz && r_idle != IDLE_MAX) ? r_idle + IW'(1) : r_idle;
    end
  assign mode    = r_mode;
  assign sel     = r_sel;
  assign inc_min = r_inc_min;
  assign inc_hr  = r_inc_hr;
  assign sec_clr = r_sec_clr;
endmodule

// File: doc/time_set_controller.md
TIME_SET_CONTROLLER -- requirements
Module: time_set_controller

Interface
REQ-001 Parameter REPEAT_DELAY, default 50_000_000, clk cycles btn_inc must be held before auto-repeat starts.
REQ-002 Parameter REPEAT_PERIOD, default 10_000_000, clk cycles between auto-repeat pulses.
REQ-003 Parameter TIMEOUT_S, default 30, tick_1hz pulses of inactivity before returning to RUN; 0 disables timeout.
REQ-004 Port clk  input  1  single system clock; all logic on rising edge.
REQ-005 Port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 Port tick_1hz  input  1  one-cycle 1 Hz pulse, synchronous to clk.
REQ-007 Port btn_mode  input  1  raw mode button, asynchronous, active-high, externally debounced.
REQ-008 Port btn_inc  input  1  raw increment button, asynchronous, active-high, externally debounced.
REQ-009 Port mode  output  2  current state: 2'b00 RUN, 2'b01 SET_MIN, 2'b10 SET_HR.
REQ-010 Port sel  output  1  increment-mux select; 1 = running tick path, 0 = manual path.
REQ-011 Port inc_min  output  1  one-cycle minute-increment pulse.
REQ-012 Port inc_hr  output  1  one-cycle hour-increment pulse.
REQ-013 Port sec_clr  output  1  one-cycle seconds-clear pulse.

Function
REQ-014 Each button SHALL pass a 2-flop synchronizer, then rising-edge detect; a press event is a one-cycle flag.
REQ-015 Outputs SHALL be registered; raw button high before edge k SHALL produce state/pulse change visible after edge k+3.
REQ-016 FSM SHALL be RUN -> SET_MIN -> SET_HR -> RUN, advancing once per btn_mode press event.
REQ-017 sel SHALL be 1 in RUN, 0 in SET_MIN and SET_HR; 2'b11 mode SHALL never occur; illegal state recovers to RUN next cycle.
REQ-018 In SET_MIN a btn_inc press SHALL pulse inc_min for exactly one cycle; in SET_HR it SHALL pulse inc_hr; in RUN btn_inc SHALL be ignored.
REQ-019 sec_clr SHALL pulse for one cycle coincident with the RUN -> SET_MIN transition only.
REQ-020 Simultaneous mode and inc press events in the same cycle: mode transition taken, inc ignored.
REQ-021 Idle counter SHALL count tick_1hz in SET states, clear on any press event or state change; reaching TIMEOUT_S SHALL force RUN next cycle.
REQ-022 Timeout and a mode press in the same cycle SHALL both resolve to RUN exactly once (no double advance).
REQ-023 inc_min and inc_hr SHALL never be high in the same cycle.
REQ-024 Counters SHALL be sized with $clog2 of their limit and SHALL saturate, never wrap.

Reset
REQ-025 On rst_n low: mode=RUN, sel=1, inc_min=0, inc_hr=0, sec_clr=0, all counters 0.
REQ-026 Synchronizer flops SHALL reset to 0 and edge-detect history flops to 1, so a button held through reset release generates no press.
REQ-027 Reset asserted mid-SET state SHALL abort immediately to RUN with no pulses emitted.

Configuration
REQ-028 Macro TIME_SET_AUTO_REPEAT_EN defined: btn_inc held continuously in a SET state for REPEAT_DELAY cycles after its press event SHALL emit one extra pulse, then one every REPEAT_PERIOD cycles until release or state change; each pulse clears the idle counter.
REQ-029 Macro undefined: exactly one pulse per press; repeat counter logic absent; REPEAT_DELAY/REPEAT_PERIOD unused.

Structure
REQ-030 Shared package clock_pkg SHALL hold mode encodings (MODE_RUN, MODE_SET_MIN, MODE_SET_HR) and the sel polarity constants.
REQ-031 Sub-module btn_sync_edge (synchronizer + edge detect, one instance per button) SHALL be used.

Verification (REPEAT_DELAY=20, REPEAT_PERIOD=5, TIMEOUT_S=3 on bench)
REQ-032 Reset, then 3 btn_mode presses -> mode 01,10,00; sel 0,0,1; sec_clr one pulse at first transition only.
REQ-033 SET_HR, 4 btn_inc presses -> exactly 4 single-cycle inc_hr pulses, inc_min stays 0.
REQ-034 SET_MIN, no presses, 3 tick_1hz pulses -> mode 00 one cycle after third tick; press after 2nd tick restarts count.
REQ-035 btn_mode and btn_inc rise same cycle in SET_MIN -> mode 10, no inc_min pulse.
REQ-036 btn_inc held high across rst_n release -> no pulse; with TIME_SET_AUTO_REPEAT_EN, hold 40 cycles in SET_MIN -> pulses at press, +20, +25, +30, +35.
